// File: rtl/console_pkg.sv
// console_pkg: shared constants and types for the console text writer.
//   NUM_ROWS / NUM_COLS : default text buffer geometry (3 x 10)
//   CELL_W              : width of one buffer cell {color[1:0], ascii[6:0]}
//   BLANK_CELL          : colour 0 space, used by scroll fill and clear
//   CH_*                : control codes recognised by the decoder
//   state_t             : writer FSM states
package console_pkg;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 10;
  localparam int CELL_W   = 9;

  localparam logic [CELL_W-1:0] BLANK_CELL = 9'h020;

  localparam logic [7:0] CH_BS         = 8'h08;
  localparam logic [7:0] CH_LF         = 8'h0A;
  localparam logic [7:0] CH_FF         = 8'h0C;
  localparam logic [7:0] CH_CR         = 8'h0D;
  localparam logic [7:0] CH_COLOR_BASE = 8'h10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  // True for the bytes that land in the buffer as a character.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // True for the four colour-select codes 0x10..0x13.
  function automatic logic is_color_code(input logic [7:0] b);
    return b[7:2] == CH_COLOR_BASE[7:2];
  endfunction

endpackage

// File: rtl/console_copy_engine.sv
// console_copy_engine: cell sequencer for whole-buffer scroll and clear.
//   clk, reset : clock, asynchronous active-high reset
//   run        : writer is in SCROLL or CLEAR (advance one cell per cycle)
//   scroll     : writer is in SCROLL (copy rows up, then blank the last row)
//   rd_data    : buffer cell at rd_addr (asynchronous read)
//   rd_addr    : source cell for the copy, 0 when not copying
//   cell_addr  : destination cell of the current step
//   cell_data  : data to write at cell_addr this step
//   last       : current step is the final cell of the sweep
// The parent registers cell_addr/cell_data onto its write port, so each
// step appears on the buffer write bus one cycle after it is presented.
module console_copy_engine
#(
  parameter int NUM_ROWS = console_pkg::NUM_ROWS,
  parameter int NUM_COLS = console_pkg::NUM_COLS,
  parameter int ADDR_W   = 5
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              scroll,
  input  logic [8:0]        rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [8:0]        cell_data,
  output logic              last
);
  import console_pkg::*;

  localparam int CELLS      = NUM_ROWS * NUM_COLS;
  localparam int COPY_CELLS = (NUM_ROWS - 1) * NUM_COLS;
  // One extra count of headroom so CELLS itself is representable.
  localparam int KW         = $clog2(CELLS + 1);

  logic [KW-1:0] k_r;
  logic          copy_s;

  // Sweep counter: walks 0..CELLS-1 while running, parked at 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r <= {KW{1'b0}};
    end else if (run) begin
      if (last) begin
        k_r <= {KW{1'b0}};
      end else begin
        k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
      end
    end else begin
      k_r <= {KW{1'b0}};
    end
  end

  // Source/destination selection: cells below the last row copy from one
  // row further down; the last row is filled with blanks.
  always_comb begin
    copy_s    = scroll && (k_r < KW'(COPY_CELLS));
    cell_addr = ADDR_W'(k_r);
    last      = (k_r == KW'(CELLS - 1));
    if (copy_s) begin
      rd_addr   = ADDR_W'(k_r + KW'(NUM_COLS));
      cell_data = rd_data;
    end else begin
      rd_addr   = {ADDR_W{1'b0}};
      cell_data = BLANK_CELL;
    end
  end

endmodule

// File: rtl/console_term_writer.sv
// console_term_writer: byte-stream front end for the 3x10 VGA text buffer.
// Decodes printable ASCII and control codes, tracks the cursor and colour,
// and issues single-cell buffer writes; LF on the bottom row scrolls and FF
// clears the buffer through console_copy_engine.
//   clk, reset             : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready : byte input handshake (accepted only in IDLE)
//   wr_en/wr_addr/wr_data  : registered buffer write port
//   rd_addr/rd_data        : buffer read port used while scrolling
//   cursor_row/cursor_col  : current cursor position
//   busy                   : scroll/clear sweep in progress
// Build option: define CONSOLE_AUTOWRAP_EN to wrap the cursor to the next
// line after a printable in the last column (scrolling on the bottom row);
// without it the cursor sticks in the last column.
module console_term_writer
#(
  parameter int NUM_ROWS = console_pkg::NUM_ROWS,
  parameter int NUM_COLS = console_pkg::NUM_COLS,
  parameter int ADDR_W   = 5
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [8:0]        rd_data,
  output logic [1:0]        cursor_row,
  output logic [3:0]        cursor_col,
  output logic              busy
);
  import console_pkg::*;

  localparam logic [1:0] ROW_MAX = 2'(NUM_ROWS - 1);
  localparam logic [3:0] COL_MAX = 4'(NUM_COLS - 1);

  state_t            state_r;
  logic [1:0]        row_r;
  logic [3:0]        col_r;
  logic [1:0]        color_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [8:0]        wr_data_r;

  logic [ADDR_W-1:0] cell_s;
  logic              eng_run_s;
  logic              eng_scroll_s;
  logic [ADDR_W-1:0] eng_addr_s;
  logic [8:0]        eng_data_s;
  logic              eng_last_s;

  // Linear cell index of the cursor and engine mode decode.
  always_comb begin
    cell_s       = ADDR_W'(row_r) * ADDR_W'(NUM_COLS) + ADDR_W'(col_r);
    eng_run_s    = (state_r != IDLE);
    eng_scroll_s = (state_r == SCROLL);
  end

  console_copy_engine #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .ADDR_W   (ADDR_W)
  ) u_copy (
    .clk       (clk),
    .reset     (reset),
    .run       (eng_run_s),
    .scroll    (eng_scroll_s),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .cell_addr (eng_addr_s),
    .cell_data (eng_data_s),
    .last      (eng_last_s)
  );

  // Writer FSM: byte decode, cursor/colour tracking and the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      row_r     <= 2'd0;
      col_r     <= 4'd0;
      color_r   <= 2'b00;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 9'h000;
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (is_printable(in_data)) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= cell_s;
              wr_data_r <= {color_r, in_data[6:0]};
              if (col_r == COL_MAX) begin
`ifdef CONSOLE_AUTOWRAP_EN
                col_r <= 4'd0;
                if (row_r == ROW_MAX) begin
                  state_r <= SCROLL;
                end else begin
                  row_r <= row_r + 2'd1;
                end
`else
                // Cursor sticks; later printables overwrite this cell.
                col_r <= col_r;
`endif
              end else begin
                col_r <= col_r + 4'd1;
              end
            end else if (in_data == CH_CR) begin
              col_r <= 4'd0;
            end else if (in_data == CH_LF) begin
              col_r <= 4'd0;
              if (row_r == ROW_MAX) begin
                state_r <= SCROLL;
              end else begin
                row_r <= row_r + 2'd1;
              end
            end else if (in_data == CH_BS) begin
              if (col_r != 4'd0) begin
                col_r <= col_r - 4'd1;
              end else begin
                col_r <= 4'd0;
              end
            end else if (in_data == CH_FF) begin
              row_r   <= 2'd0;
              col_r   <= 4'd0;
              state_r <= CLEAR;
            end else if (is_color_code(in_data)) begin
              color_r <= in_data[1:0];
            end else begin
              // Unrecognised byte: consumed with no effect.
              color_r <= color_r;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SCROLL, CLEAR: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= eng_addr_s;
          wr_data_r <= eng_data_s;
          if (eng_last_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output mapping: handshake derives directly from the state register.
  always_comb begin
    in_ready   = (state_r == IDLE);
    busy       = (state_r != IDLE);
    wr_en      = wr_en_r;
    wr_addr    = wr_addr_r;
    wr_data    = wr_data_r;
    cursor_row = row_r;
    cursor_col = col_r;
  end

endmodule

// File: tb/tb_console_term_writer.sv
// Testbench for console_term_writer: the bench owns the text buffer memory
// (asynchronous read, write on wr_en) and compares it, the cursor and the
// write traffic against a behavioural console model.
module tb_console_term_writer;
  import console_pkg::*;

  localparam int R     = 3;
  localparam int C     = 10;
  localparam int CELLS = R * C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [8:0] wr_data;
  logic [4:0] rd_addr;
  logic [8:0] rd_data;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // buffer memory owned by the bench
  logic [8:0]  vbuf    [0:CELLS-1];
  logic [8:0]  pre_val [0:CELLS-1];
  logic        preload = 1'b0;
  int          wcount  = 0;
  logic [13:0] wlog[$];

  // reference model
  logic [8:0] mmem [0:CELLS-1];
  logic [8:0] snap [0:CELLS-1];
  int         mrow, mcol;
  logic [1:0] mcolor;

  // write snapshot taken one cycle after the accept edge
  logic       s_we;
  logic [4:0] s_addr;
  logic [8:0] s_data;
  int         s_busy_cycles;

  console_term_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb rd_data = (rd_addr < 5'd30) ? vbuf[rd_addr] : 9'h000;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < CELLS; i++) vbuf[i] <= pre_val[i];
    end else if (wr_en) begin
      if (wr_addr < 5'd30) vbuf[wr_addr] <= wr_data;
      wcount <= wcount + 1;
      wlog.push_back({wr_addr, wr_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_scroll();
    for (int r = 0; r < R - 1; r++)
      for (int c = 0; c < C; c++) mmem[r*C + c] = mmem[(r+1)*C + c];
    for (int c = 0; c < C; c++) mmem[(R-1)*C + c] = 9'h020;
  endtask

  // Applies one byte to the model; returns expected writes and busy cycles.
  task automatic model_byte(input logic [7:0] b, output int ew, output int eb);
    ew = 0;
    eb = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      mmem[mrow*C + mcol] = {mcolor, b[6:0]};
      ew = 1;
      if (mcol < C - 1) begin
        mcol++;
      end else begin
`ifdef CONSOLE_AUTOWRAP_EN
        mcol = 0;
        if (mrow < R - 1) mrow++;
        else begin model_scroll(); ew += 30; eb = 30; end
`endif
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0;
      if (mrow < R - 1) mrow++;
      else begin model_scroll(); ew = 30; eb = 30; end
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      mrow = 0;
      mcol = 0;
      for (int i = 0; i < CELLS; i++) mmem[i] = 9'h020;
      ew = 30;
      eb = 30;
    end else if (b >= 8'h10 && b <= 8'h13) begin
      mcolor = b[1:0];
    end
  endtask

  // Drives one byte, optionally keeps in_valid high while busy, and waits
  // (bounded) until the sweep and its final write have completed.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_we   = wr_en;
    s_addr = wr_addr;
    s_data = wr_data;
    if (!hold) in_valid = 1'b0;
    s_busy_cycles = 0;
    while (s_busy_cycles < 100) begin
      @(negedge clk);
      if (busy) s_busy_cycles++;
      else break;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_timeout", busy, 0);
  endtask

  task automatic chk_buf(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < CELLS; i++) if (vbuf[i] !== mmem[i]) mism++;
    chk(tag, mism, 0);
  endtask

  // Full step: model, drive, compare cursor, write count and busy length.
  task automatic step(input logic [7:0] b, input bit hold);
    int ew, eb, wc0;
    model_byte(b, ew, eb);
    wc0 = wcount;
    send_byte(b, hold);
    chk("cursor_row", cursor_row, mrow);
    chk("cursor_col", cursor_col, mcol);
    chk("write_count", wcount - wc0, ew);
    chk("busy_cycles", s_busy_cycles, eb);
  endtask

  initial begin
    int lb, bad, wc0, r;
    logic [7:0] b;
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      pre_val[i] = 9'($urandom);
      mmem[i]    = pre_val[i];
    end
    mrow = 0; mcol = 0; mcolor = 2'b00;
    preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
    // reset state
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_addr", rd_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_row", cursor_row, 0);
    chk("rst_col", cursor_col, 0);

    // "A" at (0,0)
    step(8'h41, 1'b0);
    chk("A_we", s_we, 1);
    chk("A_addr", s_addr, 0);
    chk("A_data", s_data, 9'h041);
    // colour 2 then "B" at (0,1)
    step(8'h12, 1'b0);
    step(8'h42, 1'b0);
    chk("B_addr", s_addr, 1);
    chk("B_data", s_data, 9'h142);
    chk_buf("buf_after_B");

    // move to (2,4) and scroll
    step(8'h0A, 1'b0);
    step(8'h0A, 1'b0);
    step(8'h63, 1'b0);
    step(8'h64, 1'b0);
    step(8'h65, 1'b0);
    step(8'h66, 1'b0);
    chk("pre_scroll_col", cursor_col, 4);
    for (int i = 0; i < CELLS; i++) snap[i] = mmem[i];
    lb = wlog.size();
    step(8'h0A, 1'b0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (lb + i >= wlog.size()) bad++;
      else if (wlog[lb+i] !== {5'(i), (i < 20) ? snap[i+10] : 9'h020}) bad++;
    end
    chk("scroll_write_seq", bad, 0);
    chk("scroll_in_ready", in_ready, 1);
    chk_buf("buf_after_scroll");

    // clear with in_valid held during busy
    step(8'h0C, 1'b1);
    chk_buf("buf_after_clear");

    // last-column behaviour at (1,9)
    step(8'h0A, 1'b0);
    for (int i = 0; i < 9; i++) step(8'h30 + 8'(i), 1'b0);
    step(8'h5A, 1'b0);
    chk("Z_addr", s_addr, 19);
    chk("Z_data", s_data, {mcolor, 7'h5A});
    chk_buf("buf_after_Z");

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 15);
      case (r)
        8:  b = 8'h0D;
        9:  b = 8'h0A;
        10: b = 8'h08;
        11: b = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h2E;
        12: b = 8'h10 + 8'($urandom_range(0, 3));
        13: b = ($urandom_range(0, 1) == 1) ? 8'(8'h80 + $urandom_range(0, 127))
                                            : 8'($urandom_range(0, 31));
        default: b = 8'($urandom_range(32, 126));
      endcase
      step(b, 1'b0);
      if (n % 10 == 9) chk_buf("buf_random");
    end

    // reset in the middle of a scroll
    while (mrow != R - 1) step(8'h0A, 1'b0);
    for (int i = 0; i < CELLS; i++) snap[i] = mmem[i];
    wc0 = wcount;
    @(negedge clk);
    in_data  = 8'h0A;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_row", cursor_row, 0);
    chk("abort_col", cursor_col, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_in_ready", in_ready, 1);
    repeat (5) @(posedge clk);
    #1 chk("abort_writes", wcount - wc0, 6);
    for (int i = 0; i < 6; i++) mmem[i] = snap[i+10];
    mrow = 0; mcol = 0; mcolor = 2'b00;
    chk_buf("buf_after_abort");
    step(8'h51, 1'b0);
    chk("post_abort_addr", s_addr, 0);
    chk("post_abort_data", s_data, 9'h051);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
